// File: rtl/lc3b_fetch_stage.sv
// lc3b_fetch_stage: instruction fetch stage for the LC-3b pipeline.
//
// Issues one instruction-memory read at a time at the PC and places the returned
// word in the IF/ID register. A one-entry skid buffer holds a returned word while
// decode is stalled. A redirect that arrives while a read is still outstanding is
// parked in a pending register until that read's response has been discarded.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   imem_read           read request, held with a stable address until imem_resp
//   imem_address        byte address of the outstanding read (always the PC)
//   imem_resp           one-cycle pulse marking imem_rdata valid
//   imem_rdata          returned instruction word
//   stall               decode cannot accept a new IF/ID entry
//   redirect            flush and refetch from redirect_pc
//   redirect_pc         redirect target (bit 0 is ignored)
//   if_valid            IF/ID holds a live instruction
//   if_ir               instruction in IF/ID
//   if_pc               address of if_ir
//   if_pc_plus2         if_pc + 2, modulo 2^16
module lc3b_fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    output logic [15:0] if_ir,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2
);

    typedef enum logic [1:0] {
        StFetch    = 2'd0,
        StBuffered = 2'd1,
        StDrain    = 2'd2
    } state_e;

    localparam logic [15:0] ResetPcAligned = {RESET_PC[15:1], 1'b0};

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] skid_ir_q, skid_ir_d;
    logic [15:0] skid_pc_q, skid_pc_d;
    logic [15:0] pend_q, pend_d;
    logic        if_valid_q, if_valid_d;
    logic [15:0] if_ir_q, if_ir_d;
    logic [15:0] if_pc_q, if_pc_d;

    logic        ifid_free;
    logic [15:0] pc_plus2;
    logic [15:0] redirect_aligned;

    assign ifid_free        = !if_valid_q || !stall;
    assign pc_plus2         = pc_q + 16'd2;
    assign redirect_aligned = {redirect_pc[15:1], 1'b0};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        skid_ir_d  = skid_ir_q;
        skid_pc_d  = skid_pc_q;
        pend_d     = pend_q;
        if_valid_d = if_valid_q;
        if_ir_d    = if_ir_q;
        if_pc_d    = if_pc_q;

        // A consumed entry drops out unless something below replaces it.
        if (if_valid_q && !stall) begin
            if_valid_d = 1'b0;
        end

        if (redirect) begin
            if_valid_d = 1'b0;
            skid_ir_d  = 16'h0000;
            skid_pc_d  = 16'h0000;
        end

        unique case (state_q)
            StFetch: begin
                if (redirect) begin
                    if (imem_resp) begin
                        pc_d = redirect_aligned;
                    end else begin
                        // The issued read cannot be withdrawn; wait for its response.
                        pend_d  = redirect_aligned;
                        state_d = StDrain;
                    end
                end else if (imem_resp) begin
                    pc_d = pc_plus2;
                    if (ifid_free) begin
                        if_valid_d = 1'b1;
                        if_ir_d    = imem_rdata;
                        if_pc_d    = pc_q;
                    end else begin
                        skid_ir_d = imem_rdata;
                        skid_pc_d = pc_q;
                        state_d   = StBuffered;
                    end
                end
            end
            StBuffered: begin
                // No read is outstanding here, so imem_resp is not looked at.
                if (redirect) begin
                    pc_d    = redirect_aligned;
                    state_d = StFetch;
                end else if (!stall) begin
                    if_valid_d = 1'b1;
                    if_ir_d    = skid_ir_q;
                    if_pc_d    = skid_pc_q;
                    state_d    = StFetch;
                end
            end
            StDrain: begin
                if (redirect) begin
                    pend_d = redirect_aligned;
                end
                if (imem_resp) begin
                    pc_d    = redirect ? redirect_aligned : pend_q;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= ResetPcAligned;
            skid_ir_q  <= 16'h0000;
            skid_pc_q  <= 16'h0000;
            pend_q     <= 16'h0000;
            if_valid_q <= 1'b0;
            if_ir_q    <= 16'h0000;
            if_pc_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            skid_ir_q  <= skid_ir_d;
            skid_pc_q  <= skid_pc_d;
            pend_q     <= pend_d;
            if_valid_q <= if_valid_d;
            if_ir_q    <= if_ir_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign imem_read    = !reset && (state_q != StBuffered);
    assign imem_address = pc_q;
    assign if_valid     = if_valid_q;
    assign if_ir        = if_ir_q;
    assign if_pc        = if_pc_q;
    assign if_pc_plus2  = if_pc_q + 16'd2;

endmodule

// File: tb/tb_lc3b_fetch_stage.sv
module tb_lc3b_fetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;

    logic        imem_read,    w_imem_read;
    logic [15:0] imem_address, w_imem_address;
    logic        if_valid,     w_if_valid;
    logic [15:0] if_ir,        w_if_ir;
    logic [15:0] if_pc,        w_if_pc;
    logic [15:0] if_pc_plus2,  w_if_pc_plus2;

    int vectors;
    int miscompares;

    lc3b_fetch_stage #(.RESET_PC(16'h0000)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_valid     (if_valid),
        .if_ir        (if_ir),
        .if_pc        (if_pc),
        .if_pc_plus2  (if_pc_plus2)
    );

    lc3b_fetch_stage #(.RESET_PC(16'hFFFE)) u_wrap (
        .clk          (clk),
        .reset        (reset),
        .imem_read    (w_imem_read),
        .imem_address (w_imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_valid     (w_if_valid),
        .if_ir        (w_if_ir),
        .if_pc        (w_if_pc),
        .if_pc_plus2  (w_if_pc_plus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then sit 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic resp, input logic [15:0] rdata, input logic stl,
                         input logic redir, input logic [15:0] rpc);
        imem_resp   = resp;
        imem_rdata  = rdata;
        stall       = stl;
        redirect    = redir;
        redirect_pc = rpc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);

        // Reset values, sampled while reset is still held.
        reset = 1'b1;
        tick();
        tick();
        check("rst_read",     {15'd0, imem_read}, 16'd0);
        check("rst_addr",     imem_address, 16'h0000);
        check("rst_valid",    {15'd0, if_valid}, 16'd0);
        check("rst_ir",       if_ir, 16'h0000);
        check("rst_pc",       if_pc, 16'h0000);
        check("rst_plus2",    if_pc_plus2, 16'h0002);
        check("rst_wrap_addr", w_imem_address, 16'hFFFE);
        reset = 1'b0;
        #1;
        check("post_rst_read", {15'd0, imem_read}, 16'd1);
        check("post_rst_addr", imem_address, 16'h0000);

        // Back-to-back stream: 0, 2, 4, 6 on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'hA000 + 16'(2 * i), 1'b0, 1'b0, 16'h0000);
            tick();
            check("stream_valid", {15'd0, if_valid}, 16'd1);
            check("stream_pc",    if_pc, 16'(2 * i));
            check("stream_ir",    if_ir, 16'hA000 + 16'(2 * i));
            check("stream_addr",  imem_address, 16'(2 * i + 2));
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        tick();
        check("stream_drop_valid", {15'd0, if_valid}, 16'd0);

        // Stall while a response arrives: skid buffer, then release.
        do_reset();
        drive(1'b1, 16'hA000, 1'b0, 1'b0, 16'h0000);
        tick();
        check("stall_first_pc", if_pc, 16'h0000);
        drive(1'b1, 16'hA002, 1'b1, 1'b0, 16'h0000);
        tick();
        check("buf_read",  {15'd0, imem_read}, 16'd0);
        check("buf_pc",    if_pc, 16'h0000);
        check("buf_valid", {15'd0, if_valid}, 16'd1);
        check("buf_addr",  imem_address, 16'h0004);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        tick();
        check("buf_hold_read", {15'd0, imem_read}, 16'd0);
        check("buf_hold_pc",   if_pc, 16'h0000);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        tick();
        check("unbuf_pc",    if_pc, 16'h0002);
        check("unbuf_ir",    if_ir, 16'hA002);
        check("unbuf_valid", {15'd0, if_valid}, 16'd1);
        check("unbuf_read",  {15'd0, imem_read}, 16'd1);
        check("unbuf_addr",  imem_address, 16'h0004);
        drive(1'b1, 16'hA004, 1'b0, 1'b0, 16'h0000);
        tick();
        check("resume_pc", if_pc, 16'h0004);
        check("resume_ir", if_ir, 16'hA004);

        // Redirect while the read to 6 is outstanding.
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h3001);
        tick();
        check("drain_read",  {15'd0, imem_read}, 16'd1);
        check("drain_addr",  imem_address, 16'h0006);
        check("drain_valid", {15'd0, if_valid}, 16'd0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        tick();
        check("drain_hold_addr", imem_address, 16'h0006);
        drive(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000);
        tick();
        check("drain_done_addr",  imem_address, 16'h3000);
        check("drain_done_valid", {15'd0, if_valid}, 16'd0);
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000);
        tick();
        check("redir_valid", {15'd0, if_valid}, 16'd1);
        check("redir_pc",    if_pc, 16'h3000);
        check("redir_ir",    if_ir, 16'h1234);
        check("redir_plus2", if_pc_plus2, 16'h3002);

        // Redirect coincident with a response.
        drive(1'b1, 16'hBEEF, 1'b0, 1'b1, 16'h4000);
        tick();
        check("coinc_valid", {15'd0, if_valid}, 16'd0);
        check("coinc_addr",  imem_address, 16'h4000);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        tick();
        check("coinc_still_invalid", {15'd0, if_valid}, 16'd0);
        check("coinc_read", {15'd0, imem_read}, 16'd1);

        // Asynchronous reset in the middle of a drain.
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h5000);
        tick();
        check("pre_async_addr", imem_address, 16'h4000);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #2;
        reset = 1'b1;
        #1;
        check("async_read",  {15'd0, imem_read}, 16'd0);
        check("async_addr",  imem_address, 16'h0000);
        check("async_valid", {15'd0, if_valid}, 16'd0);
        check("async_plus2", if_pc_plus2, 16'h0002);
        tick();
        reset = 1'b0;
        #1;
        check("async_rel_read", {15'd0, imem_read}, 16'd1);
        check("async_rel_addr", imem_address, 16'h0000);
        check("wrap_rel_addr",  w_imem_address, 16'hFFFE);

        // Stream from here; the wrap instance fetches FFFE then 0000.
        drive(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000);
        tick();
        check("async_first_pc", if_pc, 16'h0000);
        check("wrap_pc0",       w_if_pc, 16'hFFFE);
        check("wrap_plus2",     w_if_pc_plus2, 16'h0000);
        check("wrap_addr",      w_imem_address, 16'h0000);
        drive(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000);
        tick();
        check("wrap_pc1", w_if_pc, 16'h0000);
        check("wrap_ir1", w_if_ir, 16'h2222);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
